// File: rtl/tiny16_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tiny16_uart_tx
// Purpose  : Byte FIFO followed by an asynchronous serial transmitter (8N1,
//            optionally 8E1). Consumes the tiny16 core's OUT/OUT_EN port and
//            drives a single TX pin.
// Ports    : CLK      - system clock, rising edge
//            RST      - asynchronous reset, active low
//            DATA[7:0]- byte to enqueue
//            WR       - write strobe, one write per asserted cycle
//            TX       - serial line, idles high, registered
//            BUSY     - frame on the line or FIFO non-empty
//            FULL     - FIFO holds FIFO_DEPTH entries
//            OVERRUN  - sticky, a write was dropped while FULL
// Macro    : TINY16_UART_PARITY_EN - adds an even-parity bit before stop
// Revision : 1.0 - initial release
// ============================================================================
module tiny16_uart_tx #(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA,
  input  logic       WR,
  output logic       TX,
  output logic       BUSY,
  output logic       FULL,
  output logic       OVERRUN
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TINY16_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];

  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
`ifdef TINY16_UART_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic [7:0]    head;
  logic          full;
  logic          push;
  logic          pop;
  logic          baud_done;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    // FULL comes from the pre-edge count, so a simultaneous pop never
    // makes room for a write on the same edge.
    full      = (count_q == FULL_COUNT);
    push      = WR && !full;
    baud_done = (baud_q == BAUD_LAST);

    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef TINY16_UART_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef TINY16_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + 16'd1;
        end
      end
`ifdef TINY16_UART_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d  = baud_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = head;
`ifdef TINY16_UART_PARITY_EN
      parity_d = ^head;
`endif
    end

    count_d   = count_q + CW'(push) - CW'(pop);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    wr_ptr_d  = wr_ptr_q + AW'(push);
    overrun_d = overrun_q | (WR & full);

    // TX and BUSY are registered, so derive them from the next state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef TINY16_UART_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef TINY16_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef TINY16_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= DATA;
    end
  end

  assign TX      = tx_q;
  assign BUSY    = busy_q;
  assign FULL    = full;
  assign OVERRUN = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tiny16_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny16_uart_tx
// Purpose  : Self-checking bench for tiny16_uart_tx. A frame-level reference
//            model predicts, for every cycle, TX/BUSY/FULL/OVERRUN from the
//            list of writes: each accepted byte is popped at
//            max(write edge + 1, end of previous frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tiny16_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef TINY16_UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FLEN = FB * CPB;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic       WR = 1'b0;
  logic       TX, BUSY, FULL, OVERRUN;

  tiny16_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .WR(WR),
    .TX(TX), .BUSY(BUSY), .FULL(FULL), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Reference model: accepted writes (edge, pop edge, byte) and first drop.
  int         w_q[$];
  int         p_q[$];
  logic [7:0] d_q[$];
  int         drop_edge = -1;
  int         e = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic void model_clear();
    w_q.delete(); p_q.delete(); d_q.delete();
    drop_edge = -1;
  endfunction

  function automatic void model_write(input int edge_n, input logic [7:0] d);
    int occ = 0;
    int p;
    foreach (w_q[i]) if (w_q[i] < edge_n && p_q[i] >= edge_n) occ++;
    if (occ >= DEPTH) begin
      if (drop_edge < 0) drop_edge = edge_n;
    end else begin
      p = edge_n + 1;
      if (p_q.size() > 0 && p_q[p_q.size()-1] + FLEN > p) p = p_q[p_q.size()-1] + FLEN;
      w_q.push_back(edge_n); p_q.push_back(p); d_q.push_back(d);
    end
  endfunction

  function automatic logic exp_tx(input int c);
    logic [7:0] b;
    int k;
    foreach (p_q[i]) begin
      if (c >= p_q[i] && c < p_q[i] + FLEN) begin
        k = (c - p_q[i]) / CPB;
        b = d_q[i];
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int c);
    foreach (w_q[i]) if (w_q[i] <= c && c <= p_q[i] + FLEN - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_full(input int c);
    int n = 0;
    foreach (w_q[i]) if (w_q[i] <= c && p_q[i] > c) n++;
    return (n == DEPTH);
  endfunction

  function automatic logic exp_overrun(input int c);
    return (drop_edge >= 0 && drop_edge <= c);
  endfunction

  task automatic check_outputs(input string tag);
    logic x;
    x = exp_tx(e);
    n_checks++;
    assert (TX === x) begin n_pass++; end
    else $error("FAIL %s tx cycle %0d: observed %b expected %b", tag, e, TX, x);
    x = exp_busy(e);
    n_checks++;
    assert (BUSY === x) begin n_pass++; end
    else $error("FAIL %s busy cycle %0d: observed %b expected %b", tag, e, BUSY, x);
    x = exp_full(e);
    n_checks++;
    assert (FULL === x) begin n_pass++; end
    else $error("FAIL %s full cycle %0d: observed %b expected %b", tag, e, FULL, x);
    x = exp_overrun(e);
    n_checks++;
    assert (OVERRUN === x) begin n_pass++; end
    else $error("FAIL %s overrun cycle %0d: observed %b expected %b", tag, e, OVERRUN, x);
  endtask

  // One clock: drive inputs, take the edge, update the model, check at negedge.
  task automatic cycle(input logic wr, input logic [7:0] d, input string tag);
    WR = wr;
    DATA = d;
    @(posedge CLK);
    e++;
    if (wr && RST) model_write(e, d);
    @(negedge CLK);
    check_outputs(tag);
  endtask

  initial begin
    // Reset held for 4 cycles, then 20 idle cycles.
    model_clear();
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, "reset");
    RST = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, "idle");

    // Single byte 0x55.
    cycle(1'b1, 8'h55, "single");
    for (int i = 0; i < FLEN + 10; i++) cycle(1'b0, 8'h00, "single");

    // Back-to-back 0x00 then 0xFF.
    cycle(1'b1, 8'h00, "b2b");
    cycle(1'b1, 8'hFF, "b2b");
    for (int i = 0; i < 2 * FLEN + 10; i++) cycle(1'b0, 8'h00, "b2b");

    // Overflow: six consecutive writes, the sixth is dropped.
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), "overflow");
    for (int i = 0; i < 5 * FLEN + 10; i++) cycle(1'b0, 8'h00, "overflow");

    // Reset during data bit 3 of 0xA5.
    cycle(1'b1, 8'hA5, "midreset");
    for (int i = 0; i < 18; i++) cycle(1'b0, 8'h00, "midreset");
    RST = 1'b0;
    model_clear();
    #1;
    check_outputs("async_reset");
    @(negedge CLK);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, "midreset_hold");
    RST = 1'b1;
    for (int i = 0; i < FLEN + 20; i++) cycle(1'b0, 8'h00, "after_reset");

    // Randomised writes, dense enough to fill the FIFO and drop bytes.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) == 0), 8'($urandom), "random");
    for (int i = 0; i < (DEPTH + 2) * FLEN; i++) cycle(1'b0, 8'h00, "drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tiny16_uart_tx.md
# tiny16_uart_tx

Serial output stage for the tiny16 core. It consumes the core's byte output port (`OUT`/`OUT_EN`), buffers bytes in a small FIFO, and transmits them as 8N1 asynchronous serial frames on a single `TX` pin. It sits directly downstream of `tiny16` in the top level, and its `FULL`/`OVERRUN` flags can be routed back to the core's `IN` port for polling.

## Interface

Parameters:
- `CLKS_PER_BIT`, 139 — clock cycles per serial bit (16 MHz / 115200 baud); legal range 2..65535.
- `FIFO_DEPTH`, 16 — FIFO entries; power of two, 2..256.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-low reset (0 = reset).
- `DATA`  in  8  byte to enqueue; connects to core `OUT`.
- `WR`  in  1  write strobe; connects to core `OUT_EN`. Sampled every rising edge.
- `TX`  out  1  serial line; idles high. Registered.
- `BUSY`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `FULL`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `OVERRUN`  out  1  sticky; set when a write is dropped.

## Operation

- **Reset values:** `TX`=1, `BUSY`=0, `FULL`=0, `OVERRUN`=0. FIFO is emptied and the FSM is forced to IDLE. Reset asserted mid-frame aborts the frame, and `TX` returns to 1 asynchronously.
- **FIFO write:**
  - `WR`=1 with `FULL`=0 pushes `DATA` at that edge.
  - `WR`=1 with `FULL`=1 drops the byte and sets `OVERRUN`, which is cleared only by reset.
  - A push and a pop on the same edge are both honoured, so the count is unchanged.
  - `FULL` is computed from the pre-edge count. A write is therefore rejected when `FULL`=1, even if a pop happens on that same edge.
- **Counters and pointers:**
  - Occupancy count is clog2(`FIFO_DEPTH`)+1 bits wide.
  - Read and write pointers are clog2(`FIFO_DEPTH`) bits wide and wrap modulo `FIFO_DEPTH`.
  - A pop never occurs when the FIFO is empty.
- **FSM states:** IDLE, START, DATA, (PARITY), STOP.
  - **IDLE:** `TX`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - **START:** `TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - **DATA:** `TX`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. Shift right after each bit. After bit 7, go to PARITY if enabled, otherwise STOP.
  - **STOP:** `TX`=1 for `CLKS_PER_BIT` cycles. On the last cycle:
    - if the FIFO is non-empty, pop directly and go to START, with no extra idle cycle;
    - otherwise go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and resets to 0 on each bit boundary.
- **`BUSY`:** equals (state != IDLE) OR (count != 0), registered.

## Timing

- A write at edge N into an empty FIFO with the FSM in IDLE:
  - the pop happens at edge N+1;
  - `TX` falls after edge N+1, so there is 1 cycle of latency from the write edge to the start bit.
- **Frame length:** exactly 10×`CLKS_PER_BIT` cycles (11× with parity).
- **Back-to-back frames:** the next start bit begins the cycle immediately after the last stop-bit cycle.
- **`FULL` timing:** `FULL` asserts the cycle after the push that makes count = `FIFO_DEPTH`. It deasserts the cycle after the first pop from full.
- **`OVERRUN` timing:** `OVERRUN` asserts the cycle after the dropped write.
- **Throughput:** `WR` may be asserted every cycle, and each asserted cycle is a separate write. The core must pace itself using `FULL`.

## Configuration

- **Macro:** `TINY16_UART_PARITY_EN`.
- **Defined:** a PARITY state is inserted between DATA and STOP.
  - `TX` = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles.
  - Frame is 11 bits.
- **Undefined:** the PARITY state, its logic and the parity register are absent. Frames are 8N1 (10 bits).

## Test plan

Directed scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 unless noted.

- **Reset:** hold `RST`=0 for 4 cycles, then release. Required: `TX`=1, `BUSY`=0, `FULL`=0, `OVERRUN`=0. Then 20 idle cycles: `TX` stays 1.
- **Single byte:** write 0x55 once.
  - `TX` falls one edge later.
  - Sampled every 4 cycles, `TX` reads 0,1,0,1,0,1,0,1,0,1, i.e. 40 cycles.
  - `BUSY` then drops.
- **Back-to-back:** write 0x00 then 0xFF on consecutive cycles.
  - Required: two contiguous frames of 80 cycles total, with no high gap between the 0x00 stop bit and the 0xFF start bit.
  - Second frame reads 0,1×8,1.
- **Overflow:** write 6 bytes on consecutive cycles (0x01..0x06) starting from idle.
  - The first byte is popped at the next edge, so the FIFO fills with bytes 2–5.
  - Byte 6 is dropped: `FULL`=1 and `OVERRUN`=1.
  - Bytes 1..5 are transmitted in order, then `FULL`=0. `OVERRUN` stays 1 until reset.
- **Reset mid-frame:** write 0xA5, then assert `RST` during data bit 3.
  - `TX`=1 immediately.
  - After release, the FIFO is empty, `BUSY`=0, and no further frame appears.
- **Parity** (with `TINY16_UART_PARITY_EN` defined): write 0x07.
  - Frame is 0,1,1,1,0,0,0,0,0, then parity 1, then stop 1.
  - 44 cycles total.
